fir_mac_engine: RTL and testbench

Streaming multiply-accumulate engine of the FIR accelerator, directly downstream of the streamer sources (a, b, c) and upstream of the d sink. It consumes `ctrl_engine_t` from the controller FSM and returns `flags_engine_t`. In scalar-product mode it reduces `len` shifted a·b products, adds one c bias, and emits one d word. In simple-mul mode it emits one d word per element.

---
 rtl/fir_mac_engine_pkg.sv | 48 ++++
 rtl/fir_mac_engine_if.sv | 13 +
 rtl/fir_mac_engine_mul_shift.sv | 37 +++
 rtl/fir_mac_engine.sv | 124 ++++++++++++
 tb/tb_fir_mac_engine.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_mac_engine_pkg.sv
// Shared types and arithmetic helpers for the FIR MAC engine.
// FIR_SATURATE_EN selects saturating instead of wrapping 32-bit arithmetic.
package fir_package;

  localparam int unsigned FIR_DATA_WIDTH = 32;

`ifdef FIR_SATURATE_EN
  localparam bit FIR_SAT = 1'b1;
`else
  localparam bit FIR_SAT = 1'b0;
`endif

  typedef enum logic [1:0] {
    ENG_IDLE,
    ENG_ACCUM,
    ENG_OUT
  } state_engine_t;

  typedef struct packed {
    logic        clear;
    logic        enable;
    logic        simple_mul;
    logic        start;
    logic [4:0]  shift;
    logic [10:0] len;
  } ctrl_engine_t;

  typedef struct packed {
    logic [10:0] cnt;
    logic        acc_valid;
  } flags_engine_t;

  // Narrow a 64-bit signed value to 32 bits: clamp when saturation is built in, else keep low bits.
  function automatic logic [31:0] fir_sat32(input logic [63:0] v);
    logic fits;
    fits = (v[63:31] == '0) || (v[63:31] == '1);
    if (FIR_SAT && !fits)
      return v[63] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return v[31:0];
  endfunction

  function automatic logic [31:0] fir_add(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] s;
    s = {{32{x[31]}}, x} + {{32{y[31]}}, y};
    return fir_sat32(s);
  endfunction

endpackage

// File: rtl/fir_mac_engine_if.sv
// Valid/ready/data stream interface used by the FIR streamers and engine.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport source (output valid, output data, input ready);
  modport sink   (input valid, input data, output ready);
  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fir_mac_engine_mul_shift.sv
// Registered signed multiplier with arithmetic right shift and 32-bit narrowing.
// Holds its result and valid bit while stalled.
module fir_mul_shift
  import fir_package::*;
#(
  parameter int unsigned DATA_WIDTH = FIR_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [4:0]            shift,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] p
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [2*DATA_WIDTH-1:0] shifted;

  always_comb begin
    prod    = $signed({{DATA_WIDTH{a[DATA_WIDTH-1]}}, a}) * $signed({{DATA_WIDTH{b[DATA_WIDTH-1]}}, b});
    shifted = prod >>> shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      p         <= '0;
    end else if (!stall) begin
      out_valid <= in_valid;
      if (in_valid) p <= fir_sat32(shifted);
    end
  end

endmodule

// File: rtl/fir_mac_engine.sv
// Streaming MAC engine: scalar-product reduction (sum of a*b plus one c bias) or
// per-element a*b+c. Saturating arithmetic when FIR_SATURATE_EN is defined.
module fir_mac_engine
  import fir_package::*;
#(
  parameter int unsigned DATA_WIDTH = FIR_DATA_WIDTH
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  hwpe_stream_intf_stream.sink          a_i,
  hwpe_stream_intf_stream.sink          b_i,
  hwpe_stream_intf_stream.sink          c_i,
  hwpe_stream_intf_stream.source        d_o,
  input  ctrl_engine_t                  ctrl_i,
  output flags_engine_t                 flags_o
);

  state_engine_t         state;
  logic                  mode_simple;
  logic [4:0]            shift_q;
  logic [10:0]           len_q;
  logic [10:0]           cnt;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] c_q;
  logic [DATA_WIDTH-1:0] d_data;
  logic                  d_valid;

  logic                  sync_rst;
  logic                  stall;
  logic [10:0]           len_eff;
  logic                  in_ready;
  logic                  join_ok;
  logic                  fire;
  logic                  out_c_ready;
  logic                  p_valid;
  logic [DATA_WIDTH-1:0] p;

  always_comb begin
    sync_rst    = rst_i | ctrl_i.clear;
    stall       = d_valid && !d_o.ready;
    len_eff     = (len_q == '0) ? 11'd1 : len_q;
    in_ready    = (state == ENG_ACCUM) && (cnt < len_eff) && ctrl_i.enable && !stall && !sync_rst;
    join_ok     = a_i.valid && b_i.valid && (!mode_simple || c_i.valid);
    fire        = in_ready && join_ok;
    out_c_ready = (state == ENG_OUT) && !mode_simple && !d_valid && ctrl_i.enable && !sync_rst;
  end

  always_comb begin
    a_i.ready         = in_ready;
    b_i.ready         = in_ready;
    c_i.ready         = mode_simple ? in_ready : out_c_ready;
    d_o.valid         = d_valid;
    d_o.data          = d_data;
    flags_o.cnt       = cnt;
    flags_o.acc_valid = d_valid && !mode_simple;
  end

  fir_mul_shift #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mul (
    .clk      (clk_i),
    .rst      (sync_rst),
    .stall    (stall || !ctrl_i.enable),
    .in_valid (fire),
    .a        (a_i.data),
    .b        (b_i.data),
    .shift    (shift_q),
    .out_valid(p_valid),
    .p        (p)
  );

  always_ff @(posedge clk_i) begin
    if (sync_rst) begin
      state       <= ENG_IDLE;
      mode_simple <= 1'b0;
      shift_q     <= '0;
      len_q       <= '0;
      cnt         <= '0;
      acc         <= '0;
      c_q         <= '0;
      d_data      <= '0;
      d_valid     <= 1'b0;
    end else if (ctrl_i.enable) begin
      case (state)
        ENG_IDLE: begin
          if (ctrl_i.start) begin
            mode_simple <= ctrl_i.simple_mul;
            shift_q     <= ctrl_i.shift;
            len_q       <= ctrl_i.len;
            acc         <= '0;
            cnt         <= '0;
            state       <= ENG_ACCUM;
          end
        end
        ENG_ACCUM: begin
          if (fire) cnt <= cnt + 11'd1;
          if (!mode_simple) begin
            // The product in flight is the last one once cnt has reached len_eff.
            if (p_valid) acc <= fir_add(acc, p);
            if (p_valid && cnt == len_eff) state <= ENG_OUT;
          end else begin
            if (fire) c_q <= c_i.data;
            if (!stall) begin
              d_valid <= p_valid;
              if (p_valid) d_data <= fir_add(p, c_q);
            end
            if (cnt == len_eff && !p_valid && !d_valid) state <= ENG_IDLE;
          end
        end
        ENG_OUT: begin
          if (out_c_ready && c_i.valid) begin
            d_data  <= fir_add(acc, c_i.data);
            d_valid <= 1'b1;
          end else if (d_valid && d_o.ready) begin
            d_valid <= 1'b0;
            state   <= ENG_IDLE;
          end
        end
        default: state <= ENG_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_engine.sv
// Scoreboard bench for fir_mac_engine; the reference model honours FIR_SATURATE_EN.
module tb_fir_mac_engine;
  import fir_package::*;

  typedef logic [31:0] word_q_t[$];
  typedef struct packed {
    logic [31:0] data;
    logic        accv;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  ctrl_engine_t  ctrl;
  flags_engine_t flags;

  always #5 clk = ~clk;

  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) a_s ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) b_s ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) c_s ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) d_s ();

  fir_mac_engine #(.DATA_WIDTH(32)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .a_i    (a_s),
    .b_i    (b_s),
    .c_i    (c_s),
    .d_o    (d_s),
    .ctrl_i (ctrl),
    .flags_o(flags)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_narrow(input longint v);
`ifdef FIR_SATURATE_EN
    if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (v < -64'sd2147483648) return 32'h8000_0000;
`endif
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_add(input logic [31:0] x, input logic [31:0] y);
    return m_narrow(longint'($signed(x)) + longint'($signed(y)));
  endfunction

  function automatic logic [31:0] m_prod(input logic [31:0] x, input logic [31:0] y, input logic [4:0] sh);
    longint pr;
    pr = longint'($signed(x)) * longint'($signed(y));
    pr = pr >>> sh;
    return m_narrow(pr);
  endfunction

  exp_t        sb[$];
  logic [31:0] aq[$], bq[$], cq[$];
  bit          simple_tb = 1'b0;
  bit          rnd_valid = 1'b0;
  bit          rnd_ready = 1'b0;
  bit          src_en    = 1'b1;
  bit          ab_hs, c_hs, d_hs, d_accv;
  logic [31:0] d_dat;
  int unsigned ab_count = 0;
  exp_t        e;

  // Capture what actually handshakes at each rising edge.
  always @(posedge clk) begin
    ab_hs  <= a_s.valid && a_s.ready && b_s.valid && b_s.ready && (!simple_tb || (c_s.valid && c_s.ready));
    c_hs   <= c_s.valid && c_s.ready && (!simple_tb || (a_s.valid && b_s.valid && a_s.ready));
    d_hs   <= d_s.valid && d_s.ready;
    d_dat  <= d_s.data;
    d_accv <= flags.acc_valid;
  end

  always @(negedge clk) begin
    if (ab_hs && aq.size() > 0 && bq.size() > 0) begin
      void'(aq.pop_front());
      void'(bq.pop_front());
      ab_count++;
    end
    if (c_hs && cq.size() > 0) void'(cq.pop_front());
    if (d_hs) begin
      if (sb.size() == 0) begin
        check("d_spurious", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("d_data", d_dat, e.data);
        check("acc_valid", 32'(d_accv), 32'(e.accv));
      end
    end
    a_s.valid = src_en && aq.size() > 0 && (!rnd_valid || $urandom_range(0, 3) != 0);
    b_s.valid = src_en && bq.size() > 0 && (!rnd_valid || $urandom_range(0, 3) != 0);
    c_s.valid = src_en && cq.size() > 0 && (!rnd_valid || $urandom_range(0, 3) != 0);
    a_s.data  = (aq.size() > 0) ? aq[0] : '0;
    b_s.data  = (bq.size() > 0) ? bq[0] : '0;
    c_s.data  = (cq.size() > 0) ? cq[0] : '0;
    d_s.ready = !rnd_ready || ($urandom_range(0, 1) != 0);
  end

  task automatic start_op(input bit simple, input logic [4:0] sh, input logic [10:0] len);
    @(negedge clk);
    #1;
    ab_count        = 0;
    simple_tb       = simple;
    ctrl.simple_mul = simple;
    ctrl.shift      = sh;
    ctrl.len        = len;
    ctrl.start      = 1'b1;
    @(negedge clk);
    ctrl.start      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic [10:0] len_eff);
    int unsigned i = 0;
    while (sb.size() != 0 && i < 3000) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_pending"}, 32'(sb.size()), 32'd0);
    repeat (4) @(negedge clk);
    #1;
    check({tag, "_cnt"}, 32'(flags.cnt), 32'(len_eff));
    check({tag, "_hs"}, ab_count, 32'(len_eff));
  endtask

  task automatic scalar_case(input string tag, input word_q_t av, input word_q_t bv,
                             input logic [31:0] cv, input logic [4:0] sh, input logic [10:0] len);
    logic [31:0] acc = '0;
    int unsigned n;
    n = (len == 0) ? 1 : int'(len);
    for (int unsigned i = 0; i < n; i++) begin
      acc = m_add(acc, m_prod(av[i], bv[i], sh));
      aq.push_back(av[i]);
      bq.push_back(bv[i]);
    end
    cq.push_back(cv);
    sb.push_back('{data: m_add(acc, cv), accv: 1'b1});
    start_op(1'b0, sh, len);
    wait_done(tag, 11'(n));
  endtask

  task automatic simple_case(input string tag, input word_q_t av, input word_q_t bv,
                             input word_q_t cv, input logic [4:0] sh, input logic [10:0] len);
    for (int unsigned i = 0; i < int'(len); i++) begin
      aq.push_back(av[i]);
      bq.push_back(bv[i]);
      cq.push_back(cv[i]);
      sb.push_back('{data: m_add(m_prod(av[i], bv[i], sh), cv[i]), accv: 1'b0});
    end
    start_op(1'b1, sh, len);
    wait_done(tag, len);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    word_q_t     av, bv, cv;
    logic [10:0] cnt0;
    int unsigned k;

    rst         = 1'b1;
    ctrl        = '0;
    ctrl.enable = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_d_valid", 32'(d_s.valid), 32'd0);
    check("rst_d_data", d_s.data, 32'd0);
    check("rst_a_ready", 32'(a_s.ready), 32'd0);
    check("rst_c_ready", 32'(c_s.ready), 32'd0);
    check("rst_acc_valid", 32'(flags.acc_valid), 32'd0);
    check("rst_cnt", 32'(flags.cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    av = '{32'd1, 32'd2, 32'd3, 32'd4};
    bv = '{32'd5, 32'd6, 32'd7, 32'd8};
    scalar_case("sp4", av, bv, 32'd10, 5'd0, 11'd4);

    av = '{32'd4, -32'd6, 32'd7};
    bv = '{32'd3, 32'd3, 32'd2};
    cv = '{32'd1, 32'd1, 32'd1};
    simple_case("sm3", av, bv, cv, 5'd1, 11'd3);

    av = '{32'h7FFF_FFFF, 32'h7FFF_FFFF};
    bv = '{32'h7FFF_FFFF, 32'h7FFF_FFFF};
    scalar_case("ovf", av, bv, 32'd0, 5'd0, 11'd2);

    av = '{32'd3};
    bv = '{32'd3};
    scalar_case("len0", av, bv, 32'd0, 5'd0, 11'd0);

    rnd_valid = 1'b1;
    rnd_ready = 1'b1;
    av = {}; bv = {}; cv = {};
    for (int unsigned i = 0; i < 16; i++) begin
      av.push_back($urandom());
      bv.push_back($urandom());
      cv.push_back($urandom());
    end
    scalar_case("rnd_sp", av, bv, cv[0], 5'($urandom_range(0, 31)), 11'd16);
    simple_case("rnd_sm", av, bv, cv, 5'($urandom_range(0, 31)), 11'd16);
    rnd_valid = 1'b0;
    rnd_ready = 1'b0;

    // Disable mid-stream, then clear during accumulation: no d may appear.
    for (int unsigned i = 0; i < 8; i++) begin
      aq.push_back(32'(i + 1));
      bq.push_back(32'd2);
    end
    cq.push_back(32'd5);
    start_op(1'b0, 5'd0, 11'd8);
    k = 0;
    while (ab_count < 3 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("en_reach", 32'(ab_count >= 3), 32'd1);
    ctrl.enable = 1'b0;
    #1;
    cnt0 = flags.cnt;
    repeat (5) begin
      @(negedge clk);
      #1;
      check("dis_ready", 32'(a_s.ready), 32'd0);
      check("dis_cnt", 32'(flags.cnt), 32'(cnt0));
      check("dis_d_valid", 32'(d_s.valid), 32'd0);
    end
    ctrl.enable = 1'b1;
    @(negedge clk);
    ctrl.clear = 1'b1;
    @(negedge clk);
    ctrl.clear = 1'b0;
    #1;
    src_en = 1'b0;
    aq.delete();
    bq.delete();
    cq.delete();
    check("clr_cnt", 32'(flags.cnt), 32'd0);
    check("clr_ready", 32'(a_s.ready), 32'd0);
    check("clr_d_valid", 32'(d_s.valid), 32'd0);
    repeat (20) begin
      @(negedge clk);
      #1;
      check("clr_no_d", 32'(d_s.valid), 32'd0);
    end
    src_en = 1'b1;

    av = '{32'd3};
    bv = '{32'd3};
    scalar_case("post_clr", av, bv, 32'd0, 5'd0, 11'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
